sub_serial: RTL and testbench
=============================

# sub_serial

Bit-serial N-bit subtractor for the ALU datapath, the inverse operation to the adder chain. It uses one full-subtractor cell and a borrow flip-flop, and processes one bit per clock, LSB first. Operands are captured on a start handshake. The unit produces `diff = a - b` (mod 2^WIDTH) and a borrow-out after WIDTH cycles. It trades latency for area where a ripple subtractor is too large.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; sampled on the accepting edge.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.
- `diff`  out  WIDTH  result register `a - b` mod 2^WIDTH.
- `borrow`  out  1  borrow-out of MSB; 1 iff unsigned `a < b`.
- `ovf`  out  1  signed overflow; present only with `SUB_SERIAL_OVF_EN`.

Decided: one clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE with `start`=1 at an edge:
  - Load shift registers `sa`←`a`, `sb`←`b`.
  - Clear `bin`←0 and bit counter `cnt`←0.
  - Go to RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, each edge:
  - Compute `d = sa[0]^sb[0]^bin`.
  - Compute `bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bin)`.
  - Shift `sa`, `sb` right by one.
  - Shift `d` into the MSB of the internal partial register `sd`.
  - Set `bin`←`bo` and `cnt`←`cnt`+1.
- RUN, the edge where `cnt`==WIDTH-1:
  - Copy `{d, sd[WIDTH-1:1]}` to `diff`.
  - Set `borrow`←`bo`.
  - Go to DONE.
- DONE: `done`=1 for this single cycle. The next edge goes to IDLE unconditionally.
- `start` in RUN or DONE is ignored. It is not queued.
- `a` and `b` may change freely after the accepting edge.
- `diff`, `borrow` (and `ovf`) update only on the completion edge. They hold until the next completion.
- `cnt` width is clog2(WIDTH), minimum 1. `cnt` never wraps within an operation.
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0. Internal `sa`, `sb`, `sd`, `bin`, and `cnt` reset to 0.
- `rst` in any state, including mid-RUN, aborts the operation:
  - The next state is IDLE.
  - No `done` pulse is produced.
  - Outputs clear to their reset values.
  - `rst` has priority over `start`.

## Timing
- The accepting edge is t0.
- `busy`=1 in the cycles after edges t0 .. t(WIDTH-1).
- The completion edge is tWIDTH. `done`=1 in the cycle after tWIDTH, with `diff`/`borrow` already valid.
- The earliest next accept is edge t(WIDTH+2), with `start` high in the IDLE cycle after t(WIDTH+1).
- Throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high together.

## Configuration
- Macro: `SUB_SERIAL_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - On the completion edge, `ovf` ← (a_msb != b_msb) && (d != a_msb), using the MSB bits captured at t0. One extra flop holds the captured `a` MSB and one holds the captured `b` MSB.
  - `ovf` is reset and held like `diff`.
- Undefined:
  - Port `ovf` and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Reset, then `start` with a=0x5A, b=0x3C:
  - `busy` is high for 8 cycles.
  - `done` pulses once, exactly 8 cycles after the accept edge.
  - Result: `diff`=0x1E, `borrow`=0, `ovf`=0.
- a=0x00, b=0x01: `diff`=0xFF, `borrow`=1, `ovf`=0.
- a=0x80, b=0x01: `diff`=0x7F, `borrow`=0, `ovf`=1.
- a=0x7F, b=0xFF: `diff`=0x80, `borrow`=1, `ovf`=1.
- a=0x33, b=0x33: `diff`=0x00, `borrow`=0, `ovf`=0.
- Ignored start:
  - Accept a=0x10, b=0x01.
  - At cycle 3, pulse `start` with a=0xFF, b=0x00.
  - Result is `diff`=0x0F. There is exactly one `done` pulse.
  - The FSM returns to IDLE.
- Reset mid-operation:
  - Accept a=0x5A, b=0x3C. Assert `rst` at cycle 4.
  - No `done` pulse. `diff`, `borrow`, `ovf` are 0. State is IDLE.
  - A fresh start with a=0x02, b=0x03 completes with `diff`=0xFF, `borrow`=1.

Source files
------------

// File: rtl/sub_serial.sv
// sub_serial: bit-serial a-b subtractor, one bit per clock LSB first, optional signed overflow via SUB_SERIAL_OVF_EN
//   clk, rst (sync active-high); start/a/b request; busy, done, diff, borrow, ovf (only with SUB_SERIAL_OVF_EN)
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] sa, sb, sd;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             d, bo, last;
`ifdef SUB_SERIAL_OVF_EN
  logic             a_msb, b_msb;
`endif
  assign d    = sa[0] ^ sb[0] ^ bin;
  assign bo   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        sa    <= a;
        sb    <= b;
        bin   <= 1'b0;
        cnt   <= '0;
`ifdef SUB_SERIAL_OVF_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sd  <= {d, sd[WIDTH-1:1]};
      bin <= bo;
      cnt <= cnt + 1'b1;
      if (last) begin
        state  <= DONE;
        diff   <= {d, sd[WIDTH-1:1]};
        borrow <= bo;
`ifdef SUB_SERIAL_OVF_EN
        ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed vector bench for sub_serial at WIDTH=8
module tb_sub_serial;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrow;
  logic [7:0] diff;
`ifdef SUB_SERIAL_OVF_EN
  logic       ovf;
`endif
  int total = 0, bad = 0;

  sub_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
`ifdef SUB_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, d;
    logic       bo, ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ovf(input string name, input logic exp);
`ifdef SUB_SERIAL_OVF_EN
    chk(name, ovf, exp);
`endif
  endtask

  // kind 0: plain op, 1: start pulse at sample gn, 2: rst pulse at sample gn
  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input int gn, input int kind,
                    output int busy_cnt, output int done_at, output int done_cnt, output logic idle_end);
    busy_cnt = 0; done_at = -1; done_cnt = 0; idle_end = 1'b0;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      chk("busy_done_overlap", {31'd0, busy & done}, 32'd0);
      idle_end = !busy && !done;
      if (n == 0) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      start = (kind == 1 && n == gn);
      rst   = (kind == 2 && n == gn);
      if (kind == 1 && n == gn) begin
        a = 8'hFF; b = 8'h00;
      end
    end
    start = 1'b0; rst = 1'b0;
  endtask

  vec_t vt[6];
  int bc, da, dc;
  logic ie;

  initial begin
    vt[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vt[4] = '{8'h33, 8'h33, 8'h00, 1'b0, 1'b0};
    vt[5] = '{8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk_ovf("rst_ovf", 1'b0);
    for (int i = 0; i < 6; i++) begin
      op(vt[i].a, vt[i].b, 0, 0, bc, da, dc, ie);
      chk($sformatf("v%0d_busy_cycles", i), bc, 8);
      chk($sformatf("v%0d_done_at", i), da, 8);
      chk($sformatf("v%0d_done_cnt", i), dc, 1);
      chk($sformatf("v%0d_diff", i), diff, vt[i].d);
      chk($sformatf("v%0d_borrow", i), borrow, vt[i].bo);
      chk_ovf($sformatf("v%0d_ovf", i), vt[i].ov);
    end
    op(8'h10, 8'h01, 3, 1, bc, da, dc, ie);
    chk("ign_diff", diff, 8'h0F);
    chk("ign_borrow", borrow, 0);
    chk("ign_done_cnt", dc, 1);
    chk("ign_done_at", da, 8);
    chk("ign_idle", ie, 1);
    op(8'h5A, 8'h3C, 4, 2, bc, da, dc, ie);
    chk("abort_done_cnt", dc, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    chk_ovf("abort_ovf", 1'b0);
    chk("abort_idle", ie, 1);
    op(8'h02, 8'h03, 0, 0, bc, da, dc, ie);
    chk("fresh_diff", diff, 8'hFF);
    chk("fresh_borrow", borrow, 1);
    chk("fresh_done_at", da, 8);
    chk_ovf("fresh_ovf", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
